// File: rtl/mb_pkg.sv
// rtl/mb_pkg.sv - shared types and constants for the math box bus sequencer
// Holds the sequencer state enum, math box register addresses, the
// compute-address decode and the requester count.
package mb_pkg;

    localparam int NREQ = 2;

    localparam logic [7:0] MB_STATUS = 8'h00;
    localparam logic [7:0] MB_OUT_LO = 8'h10;
    localparam logic [7:0] MB_OUT_HI = 8'h18;

    // Status value reported by an idle math box
    localparam logic [7:0] MB_IDLE   = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREPOLL,
        ST_ISSUE,
        ST_POLL,
        ST_RDLO,
        ST_RDHI,
        ST_RDLAST,
        ST_DONE
    } mb_sched_state_t;

    // Writes to these addresses start a computation and make the box busy
    function automatic logic is_compute(input logic [7:0] addr);
        case (addr)
            8'h6B, 8'h71, 8'h72, 8'h73, 8'h74: is_compute = 1'b1;
            default:                            is_compute = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mb_rr_arb.sv
// rtl/mb_rr_arb.sv - two-way round-robin grant for the math box bus
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   i_req      request levels of both requesters
//   i_upd      pulse: a transaction of requester i_upd_id just completed
//   i_upd_id   id of the completed requester
//   o_gnt_v    some requester is asking
//   o_gnt_id   requester that would be granted this cycle
module mb_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    input  logic       i_upd_id,
    output logic       o_gnt_v,
    output logic       o_gnt_id
);

    // Points at the preferred requester: the one not served last
    logic r_rr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
        end else if (i_upd) begin
            r_rr_ptr <= ~i_upd_id;
        end
    end

    always_comb begin
        o_gnt_v  = |i_req;
        o_gnt_id = r_rr_ptr;
        if (!i_req[r_rr_ptr]) begin
            o_gnt_id = ~r_rr_ptr;
        end
    end

endmodule

// File: rtl/mb_sched.sv
// rtl/mb_sched.sv - sequencer/arbiter owning the Battlezone math box bus
// Runs each granted transaction end to end: write (or read), busy polling of
// status after compute writes, then the two-byte result read.
// Optional feature macro: MB_SCHED_PERF_EN adds perf_busy / perf_tmo counters.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req[1:0]              request levels, held until ack
//   req_addr/req_wdata    per-requester address and write data
//   req_we[1:0]           1 = write transaction, 0 = single-byte read
//   ack[1:0]              one-cycle completion pulse
//   rdata[15:0], err      result and timeout flag, valid with ack
//   mb_addr/mb_di/mb_we   math box bus outputs
//   mb_dout               registered math box data (addr of previous cycle)
//   perf_busy, perf_tmo   (MB_SCHED_PERF_EN only) busy cycles, timeouts
module mb_sched
    import mb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0][7:0] req_addr,
    input  logic [NREQ-1:0][7:0] req_wdata,
    input  logic [NREQ-1:0]      req_we,
    output logic [NREQ-1:0]      ack,
    output logic [15:0]          rdata,
    output logic                 err,
    output logic [7:0]           mb_addr,
    output logic [7:0]           mb_di,
    output logic                 mb_we,
`ifdef MB_SCHED_PERF_EN
    output logic [31:0]          perf_busy,
    output logic [15:0]          perf_tmo,
`endif
    input  logic [7:0]           mb_dout
);

    mb_sched_state_t r_state, w_state_nxt;

    logic [7:0]  r_addr;
    logic [7:0]  r_wdata;
    logic        r_we;
    logic        r_id;
    logic        r_stale;
    logic        r_poll_v;
    logic [15:0] r_poll_cnt;
    logic [7:0]  r_lo;
    logic        r_err;

    logic w_gnt_v;
    logic w_gnt_id;
    logic w_take;
    logic w_done;
    logic w_box_idle;
    logic w_poll_fail;
    logic w_tmo;
    logic w_pre_ok;

    mb_rr_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    (req),
        .i_upd    (w_done),
        .i_upd_id (r_id),
        .o_gnt_v  (w_gnt_v),
        .o_gnt_id (w_gnt_id)
    );

    assign w_take      = (r_state == ST_IDLE) && w_gnt_v;
    assign w_done      = (r_state == ST_DONE);
    assign w_box_idle  = (mb_dout == MB_IDLE);
    // The first sample in a polling state still reflects the previous address
    assign w_poll_fail = (r_state == ST_POLL) && r_poll_v && !w_box_idle;
    assign w_tmo       = w_poll_fail && (r_poll_cnt == 16'(TIMEOUT_CYC - 1));
    assign w_pre_ok    = (r_state == ST_PREPOLL) && r_poll_v && w_box_idle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= 8'h00;
            r_wdata    <= 8'h00;
            r_we       <= 1'b0;
            r_id       <= 1'b0;
            r_stale    <= 1'b0;
            r_poll_v   <= 1'b0;
            r_poll_cnt <= 16'h0000;
            r_lo       <= 8'h00;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_take) begin
                r_addr  <= req_addr[w_gnt_id];
                r_wdata <= req_wdata[w_gnt_id];
                r_we    <= req_we[w_gnt_id];
                r_id    <= w_gnt_id;
                r_err   <= 1'b0;
            end

            r_poll_v <= (r_state == ST_POLL) || (r_state == ST_PREPOLL);

            if (r_state != ST_POLL) begin
                r_poll_cnt <= 16'h0000;
            end else if (w_poll_fail) begin
                r_poll_cnt <= r_poll_cnt + 16'h0001;
            end

            if ((r_state == ST_RDHI) || (r_state == ST_RDLAST)) begin
                r_lo <= mb_dout;
            end

            // A timed-out box may still be busy; the next grant must wait it out
            if (w_tmo) begin
                r_err   <= 1'b1;
                r_stale <= 1'b1;
            end else if (w_pre_ok) begin
                r_stale <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ack         = '0;
        rdata       = 16'h0000;
        err         = 1'b0;
        mb_addr     = 8'h00;
        mb_di       = 8'h00;
        mb_we       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_gnt_v) begin
                    w_state_nxt = r_stale ? ST_PREPOLL : ST_ISSUE;
                end
            end
            ST_PREPOLL: begin
                mb_addr = MB_STATUS;
                if (w_pre_ok) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mb_addr = r_addr;
                if (r_we) begin
                    mb_di = r_wdata;
                    mb_we = 1'b1;
                    w_state_nxt = is_compute(r_addr) ? ST_POLL : ST_RDLO;
                end else begin
                    w_state_nxt = ST_RDLAST;
                end
            end
            ST_POLL: begin
                mb_addr = MB_STATUS;
                if (r_poll_v && w_box_idle) begin
                    w_state_nxt = ST_RDLO;
                end else if (w_tmo) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_RDLO: begin
                mb_addr     = MB_OUT_LO;
                w_state_nxt = ST_RDHI;
            end
            ST_RDHI: begin
                mb_addr     = MB_OUT_HI;
                w_state_nxt = ST_DONE;
            end
            ST_RDLAST: begin
                mb_addr     = r_addr;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                ack[r_id] = 1'b1;
                err       = r_err;
                // High byte arrives this cycle from the OUT_HI read
                if (r_err) begin
                    rdata = 16'hFFFF;
                end else if (r_we) begin
                    rdata = {mb_dout, r_lo};
                end else begin
                    rdata = {8'h00, r_lo};
                end
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef MB_SCHED_PERF_EN
    logic [31:0] r_perf_busy;
    logic [15:0] r_perf_tmo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_busy <= 32'h0;
            r_perf_tmo  <= 16'h0;
        end else begin
            if ((r_state != ST_IDLE) && (r_perf_busy != 32'hFFFF_FFFF)) begin
                r_perf_busy <= r_perf_busy + 32'h1;
            end
            if (w_tmo && (r_perf_tmo != 16'hFFFF)) begin
                r_perf_tmo <= r_perf_tmo + 16'h1;
            end
        end
    end

    assign perf_busy = r_perf_busy;
    assign perf_tmo  = r_perf_tmo;
`endif

endmodule

// File: tb/tb_mb_sched.sv
// tb/tb_mb_sched.sv - directed self-checking bench for mb_sched with a math box stub
module tb_mb_sched;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      req = 2'b00;
    logic [1:0][7:0] req_addr = '0;
    logic [1:0][7:0] req_wdata = '0;
    logic [1:0]      req_we = 2'b00;
    logic [1:0]      ack;
    logic [15:0]     rdata;
    logic            err;
    logic [7:0]      mb_addr;
    logic [7:0]      mb_di;
    logic            mb_we;
    logic [7:0]      mb_dout;
`ifdef MB_SCHED_PERF_EN
    logic [31:0]     perf_busy;
    logic [15:0]     perf_tmo;
`endif

    int n_vec = 0;
    int n_bad = 0;

    mb_sched #(.TIMEOUT_CYC(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_we    (req_we),
        .ack       (ack),
        .rdata     (rdata),
        .err       (err),
        .mb_addr   (mb_addr),
        .mb_di     (mb_di),
        .mb_we     (mb_we),
`ifdef MB_SCHED_PERF_EN
        .perf_busy (perf_busy),
        .perf_tmo  (perf_tmo),
`endif
        .mb_dout   (mb_dout)
    );

    always #5 clk = ~clk;

    // Math box stub: 0x60 sets result low, 0x61 sets result high, compute
    // addresses load {d,~d} and go busy for busy_len cycles, others hit memory.
    bit         stuck = 1'b0;
    int         busy_len = 3;
    logic [7:0] st_mem [256];
    logic [7:0] st_lo, st_hi, st_dout;
    int         st_busy;

    assign mb_dout = st_dout;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            st_lo   <= 8'h00;
            st_hi   <= 8'h00;
            st_dout <= 8'h00;
            st_busy <= 0;
        end else begin
            case (mb_addr)
                8'h00:   st_dout <= stuck ? 8'hFF : ((st_busy != 0) ? 8'h80 : 8'h00);
                8'h10:   st_dout <= st_lo;
                8'h18:   st_dout <= st_hi;
                default: st_dout <= st_mem[mb_addr];
            endcase
            if (mb_we) begin
                case (mb_addr)
                    8'h60: st_lo <= mb_di;
                    8'h61: st_hi <= mb_di;
                    8'h6B, 8'h71, 8'h72, 8'h73, 8'h74: begin
                        st_busy <= busy_len;
                        st_hi   <= mb_di;
                        st_lo   <= ~mb_di;
                    end
                    default: st_mem[mb_addr] <= mb_di;
                endcase
            end else if (st_busy > 0) begin
                st_busy <= st_busy - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise one request, count clock edges until its ack (1 edge = ISSUE)
    task automatic run_txn(input int id, input logic [7:0] a, input logic [7:0] d,
                           input logic we, input int budget,
                           output int n, output logic [15:0] rd, output logic er,
                           output int wes);
        bit got;
        @(negedge clk);
        req_addr[id]  = a;
        req_wdata[id] = d;
        req_we[id]    = we;
        req[id]       = 1'b1;
        n = 0; wes = 0; got = 0; rd = 16'h0; er = 1'b0;
        while (!got && n < budget) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (mb_we) wes++;
            if (ack[id]) begin
                got = 1;
                rd = rdata;
                er = err;
                req[id] = 1'b0;
            end
        end
        if (!got) begin
            req[id] = 1'b0;
            n = -1;
        end
    endtask

    initial begin
        int n, wes, k, cyc, dbl, nz, acks;
        logic [15:0] rd;
        logic er;
        int order [4];
        logic [15:0] rds [4];

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_mbwe", 32'(mb_we), 0);
        chk("rst_mbaddr", 32'(mb_addr), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ack", 32'(ack), 0);

        // Preload stub memory through the scheduler
        run_txn(1, 8'h40, 8'hC3, 1'b1, 50, n, rd, er, wes);
        chk("pre40_lat", 32'(n), 4);
        chk("pre40_rdata", 32'(rd), 32'h0000);
        run_txn(1, 8'h41, 8'h3C, 1'b1, 50, n, rd, er, wes);
        chk("pre41_lat", 32'(n), 4);

        // Contention: both held for four transactions, rr_ptr is 0 here
        @(negedge clk);
        req_addr[0] = 8'h40; req_we[0] = 1'b0;
        req_addr[1] = 8'h41; req_we[1] = 1'b0;
        req = 2'b11;
        k = 0; cyc = 0; dbl = 0;
        while (k < 4 && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (ack == 2'b11) dbl++;
            if (ack != 2'b00) begin
                order[k] = int'(ack[1]);
                rds[k] = rdata;
                k++;
                if (k == 4) req = 2'b00;
            end
        end
        req = 2'b00;
        chk("ctn_count", 32'(k), 4);
        chk("ctn_double", 32'(dbl), 0);
        chk("ctn_ord0", 32'(order[0]), 0);
        chk("ctn_ord1", 32'(order[1]), 1);
        chk("ctn_ord2", 32'(order[2]), 0);
        chk("ctn_ord3", 32'(order[3]), 1);
        chk("ctn_rd0", 32'(rds[0]), 32'h00C3);
        chk("ctn_rd1", 32'(rds[1]), 32'h003C);

        // Plain write with result-high preloaded to 0x12
        run_txn(0, 8'h61, 8'h12, 1'b1, 50, n, rd, er, wes);
        chk("hi_rdata", 32'(rd), 32'h1200);
        run_txn(0, 8'h60, 8'h34, 1'b1, 50, n, rd, er, wes);
        chk("pw_lat", 32'(n), 4);
        chk("pw_rdata", 32'(rd), 32'h1234);
        chk("pw_err", 32'(er), 0);
        chk("pw_we_cnt", 32'(wes), 1);

        // Compute write, box busy 3 cycles: 5 POLL cycles -> ack 8 after ISSUE
        busy_len = 3;
        run_txn(0, 8'h6B, 8'h5A, 1'b1, 50, n, rd, er, wes);
        chk("cmp_lat", 32'(n), 9);
        chk("cmp_rdata", 32'(rd), 32'h5AA5);
        chk("cmp_err", 32'(er), 0);

        // Single-byte read of status
        run_txn(1, 8'h00, 8'h00, 1'b0, 50, n, rd, er, wes);
        chk("rd_lat", 32'(n), 3);
        chk("rd_rdata", 32'(rd), 32'h0000);
        chk("rd_we_cnt", 32'(wes), 0);

        // Timeout: 1 invalid + 64 valid POLL samples, DONE at ISSUE+66
        stuck = 1'b1;
        run_txn(0, 8'h72, 8'h11, 1'b1, 200, n, rd, er, wes);
        chk("tmo_lat", 32'(n), 67);
        chk("tmo_err", 32'(er), 1);
        chk("tmo_rdata", 32'(rd), 32'hFFFF);

        // Stale: next grant waits in PREPOLL until status reads idle
        @(negedge clk);
        req_addr[1] = 8'h60; req_wdata[1] = 8'h77; req_we[1] = 1'b1;
        req[1] = 1'b1;
        wes = 0; nz = 0; acks = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (mb_we) wes++;
            if (mb_addr != 8'h00) nz++;
            if (ack != 2'b00) acks++;
        end
        chk("stale_we", 32'(wes), 0);
        chk("stale_addr", 32'(nz), 0);
        chk("stale_ack", 32'(acks), 0);
        stuck = 1'b0;
        n = 0; acks = 0; rd = 16'h0;
        while (acks == 0 && n < 30) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (mb_we) wes++;
            if (ack[1]) begin
                acks = 1;
                rd = rdata;
                er = err;
                req[1] = 1'b0;
            end
        end
        req[1] = 1'b0;
        chk("stale_lat", 32'(n), 5);
        chk("stale_rdata", 32'(rd), 32'h1177);
        chk("stale_we_cnt", 32'(wes), 1);

        // Reset mid-POLL
        busy_len = 20;
        @(negedge clk);
        req_addr[0] = 8'h73; req_wdata[0] = 8'h22; req_we[0] = 1'b1;
        req[0] = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rpoll_ack", 32'(ack), 0);
        chk("rpoll_we", 32'(mb_we), 0);
        chk("rpoll_rdata", 32'(rdata), 0);
        req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Reset while ISSUE drives a write
        @(negedge clk);
        req_addr[0] = 8'h60; req_wdata[0] = 8'h99; req_we[0] = 1'b1;
        req[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("riss_we_before", 32'(mb_we), 1);
        rst = 1'b1;
        #1;
        chk("riss_we", 32'(mb_we), 0);
        chk("riss_addr", 32'(mb_addr), 0);
        chk("riss_di", 32'(mb_di), 0);
        req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // No leftover ack from aborted transactions
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack != 2'b00) acks++;
        end
        chk("post_rst_ack", 32'(acks), 0);

        // Normal transaction after reset (stub result registers were reset)
        run_txn(1, 8'h60, 8'h55, 1'b1, 50, n, rd, er, wes);
        chk("post_lat", 32'(n), 4);
        chk("post_rdata", 32'(rd), 32'h0055);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
